decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I Decode stage, directly downstream of Fetch.
- Consumes InstrD/PCD/PCPlus4D and holds the 32x32 architectural register file (written from Writeback).
- Generates immediates and control; registers everything into the ID/EX pipeline register feeding Execute.
- Exposes source register indices combinationally to the hazard unit.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- NREGS, 32, register file depth (index width 5).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- InstrD  in  32  instruction from Fetch pipeline register.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  writeback write enable.
- RdW  in  5  writeback destination.
- ResultW  in  32  writeback data.
- StallE  in  1  hold ID/EX register.
- FlushE  in  1  insert bubble into ID/EX register.
- Rs1D, Rs2D  out  5  combinational source indices (0 when the format has no such source).
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE  out  1 each  registered control.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- Funct3E  out  3  registered funct3 (branch/load/store size).
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data.
- Rs1E, Rs2E, RdE  out  5 each  registered indices.

Behaviour:
- Reset (rst=0, async):
  - All ID/EX outputs = 0.
  - All 32 registers = 0.
- Register file:
  - Writes on posedge when RegWriteW=1 and RdW!=0.
  - x0 always reads 0; writes to x0 are ignored.
  - Reads are combinational and write-first: if RegWriteW=1, RdW!=0 and RdW==Rs1D/Rs2D, the read returns ResultW in the same cycle.
- Immediates by opcode:
  - I-type (0010011, 0000011, 1100111): sign-extended [31:20].
  - S-type (0100011): {[31:25],[11:7]}.
  - B-type (1100011): {[31],[7],[30:25],[11:8],0}.
  - U-type (0110111, 0010111): {[31:12],12'b0}.
  - J-type (1101111): {[31],[19:12],[20],[30:21],0}.
  - All sign-extended to 32 bits.
- Control decode:
  - R-type: funct7[5] selects SUB/SRA.
  - I-type ALU: funct7[5] is used only for SRAI.
  - LUI: ALU ADD, Rs1D forced to 0, ALUSrcE=1.
  - AUIPC: ALUSrcAE=1 (PC operand), ALUSrcE=1.
  - JAL/JALR: JumpE=1, ResultSrcE=10, RegWriteE=1.
  - Branch: BranchE=1, ALU SUB.
  - Load: ResultSrcE=01. Store: MemWriteE=1, RegWriteE=0.
  - Unknown opcode decodes as a NOP: all enables 0.
- ID/EX register, each posedge, in priority order:
  1. FlushE=1: clears all outputs to 0 (bubble). Flush wins over a simultaneous StallE.
  2. StallE=1: holds all outputs.
  3. Otherwise: loads the decoded values.
- Latency: one cycle from InstrD to the E outputs.
- A same-cycle writeback to a register being read is captured with the new value, via the write-first bypass.
- Reset asserted mid-operation clears the pipeline register and the register file immediately, without waiting for a clock edge.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Enabled:
  - Adds output IllegalE (1 bit), registered alongside the other E outputs and flushed/held with them.
  - IllegalE=1 for an unknown opcode, or an invalid funct3/funct7 combination in R-type/shift-immediate.
  - The instruction still issues as a NOP.
- Disabled:
  - Port is absent.
  - Illegal encodings issue silently as NOPs.

Test Plan:
- Reset: hold rst=0 with InstrD=0x00500093 -> all E outputs 0; release, one clock -> RegWriteE=1, ImmExtE=5, RdE=1, ALUControlE=0000.
- Bypass: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, InstrD=0x003100B3 (add x1,x2,x3), same cycle -> after the edge RD2E=0xDEADBEEF.
- x0 protection: write RdW=0, ResultW=0x1234, then read x0 -> RD1E=0.
- Immediate: InstrD=0xFE000EE3 (beq, offset -4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=0001.
- Flush vs stall: StallE=1 and FlushE=1 on the same edge -> all E outputs 0; StallE=1 alone on the next edge -> values held.
- Illegal (macro on): InstrD=0xFFFFFFFF -> IllegalE=1, RegWriteE=0, MemWriteE=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage.
// Holds the 32x32 register file (written from Writeback, write-first reads),
// decodes control and immediates from InstrD, and registers everything into
// the ID/EX pipeline register that feeds Execute.
// Optional build macro: DECODE_ILLEGAL_TRAP_EN adds the registered IllegalE
// output. Without it, illegal encodings still issue as silent NOPs.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic            ALUSrcAE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      Funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            IllegalE
`endif
);

    // Opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // ID/EX payload width: 6 flags, ResultSrc, ALUControl, funct3,
    // five data words, three register indices, illegal flag.
    localparam int IDEX_W = 6 + 2 + 4 + 3 + 5 * XLEN + 15 + 1;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd_f;
    logic [2:0] funct3;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [6:0] funct7;

    assign opcode = InstrD[6:0];
    assign rd_f   = InstrD[11:7];
    assign funct3 = InstrD[14:12];
    assign rs1_f  = InstrD[19:15];
    assign rs2_f  = InstrD[24:20];
    assign funct7 = InstrD[31:25];

    // Decoded values (D side)
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_rd;
    logic            use_f3;
    logic            reg_write_d;
    logic            mem_write_d;
    logic            jump_d;
    logic            branch_d;
    logic            alu_src_d;
    logic            alu_src_a_d;
    logic [1:0]      result_src_d;
    logic [3:0]      alu_ctl_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    logic [4:0]      rd_d;
    logic [2:0]      funct3_d;

    // Register file; entry 0 exists but is never written and never read.
    logic [XLEN-1:0] regs [NREGS];

    logic [IDEX_W-1:0] idex_d;
    logic [IDEX_W-1:0] idex_q;

    // Map funct3 (plus the SUB/SRA alternate bit) to an ALU operation.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Legality: known opcode, and valid funct7 for R-type and shift-immediates.
    always_comb begin
        legal = 1'b1;
        case (opcode)
            OP_R: begin
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OP_I: begin
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Control and immediate decode; anything illegal collapses to an all-zero NOP.
    always_comb begin
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        use_rd       = 1'b0;
        use_f3       = 1'b0;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_src_d    = 1'b0;
        alu_src_a_d  = 1'b0;
        result_src_d = 2'b00;
        alu_ctl_d    = ALU_ADD;
        imm_d        = '0;
        if (legal) begin
            case (opcode)
                OP_R: begin
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                    use_rd      = 1'b1;
                    use_f3      = 1'b1;
                    reg_write_d = 1'b1;
                    alu_ctl_d   = alu_op(funct3, funct7[5]);
                end
                OP_I: begin
                    use_rs1     = 1'b1;
                    use_rd      = 1'b1;
                    use_f3      = 1'b1;
                    reg_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                    // Only SRAI takes the alternate encoding; ADDI never subtracts.
                    alu_ctl_d   = alu_op(funct3, funct7[5] && (funct3 == 3'b101));
                    imm_d       = {{20{InstrD[31]}}, InstrD[31:20]};
                end
                OP_LOAD: begin
                    use_rs1      = 1'b1;
                    use_rd       = 1'b1;
                    use_f3       = 1'b1;
                    reg_write_d  = 1'b1;
                    alu_src_d    = 1'b1;
                    result_src_d = 2'b01;
                    imm_d        = {{20{InstrD[31]}}, InstrD[31:20]};
                end
                OP_STORE: begin
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                    use_f3      = 1'b1;
                    mem_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                    imm_d       = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                end
                OP_BRANCH: begin
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    use_f3    = 1'b1;
                    branch_d  = 1'b1;
                    alu_ctl_d = ALU_SUB;
                    imm_d     = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                                 InstrD[30:25], InstrD[11:8], 1'b0};
                end
                OP_JAL: begin
                    use_rd       = 1'b1;
                    jump_d       = 1'b1;
                    reg_write_d  = 1'b1;
                    result_src_d = 2'b10;
                    imm_d        = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                    InstrD[20], InstrD[30:21], 1'b0};
                end
                OP_JALR: begin
                    use_rs1      = 1'b1;
                    use_rd       = 1'b1;
                    use_f3       = 1'b1;
                    jump_d       = 1'b1;
                    reg_write_d  = 1'b1;
                    alu_src_d    = 1'b1;
                    result_src_d = 2'b10;
                    imm_d        = {{20{InstrD[31]}}, InstrD[31:20]};
                end
                OP_LUI: begin
                    use_rd      = 1'b1;
                    reg_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                    imm_d       = {InstrD[31:12], 12'b0};
                end
                OP_AUIPC: begin
                    use_rd      = 1'b1;
                    reg_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                    alu_src_a_d = 1'b1;
                    imm_d       = {InstrD[31:12], 12'b0};
                end
                default: begin
                    use_rs1 = 1'b0;
                end
            endcase
        end
    end

    assign Rs1D     = use_rs1 ? rs1_f : 5'd0;
    assign Rs2D     = use_rs2 ? rs2_f : 5'd0;
    assign rd_d     = use_rd ? rd_f : 5'd0;
    assign funct3_d = use_f3 ? funct3 : 3'd0;

    // Register file write port: x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regs[RdW] <= ResultW;
        end
    end

    // Write-first reads: a same-cycle writeback to a source is bypassed.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (Rs1D != 5'd0) begin
            rd1_d = (RegWriteW && (RdW == Rs1D)) ? ResultW : regs[Rs1D];
        end
        if (Rs2D != 5'd0) begin
            rd2_d = (RegWriteW && (RdW == Rs2D)) ? ResultW : regs[Rs2D];
        end
    end

    assign idex_d = {reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, alu_src_a_d,
                     result_src_d, alu_ctl_d, funct3_d,
                     rd1_d, rd2_d, imm_d, PCD, PCPlus4D,
                     Rs1D, Rs2D, rd_d, ~legal};

    // ID/EX register: flush beats stall, stall holds, otherwise load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else if (!StallE) begin
            idex_q <= idex_d;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE,
            ResultSrcE, ALUControlE, Funct3E,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
            Rs1E, Rs2E, RdE, IllegalE} = idex_q;
`else
    logic illegal_unused;
    assign {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE,
            ResultSrcE, ALUControlE, Funct3E,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
            Rs1E, Rs2E, RdE, illegal_unused} = idex_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage with an expected-value
// queue. The driver pushes the hand-computed ID/EX contents for each edge;
// the monitor pops and compares one entry after every rising edge.
module tb_decode_stage;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        alu_src_a;
        logic [1:0]  result_src;
        logic [3:0]  alu_ctl;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } e_t;

    localparam int W = $bits(e_t);

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, StallE, FlushE;
    logic [4:0]  RdW, Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ill_act;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           failures;
    e_t           last_e;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE),
        .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .IllegalE(ill_act)
`endif
    );

`ifndef DECODE_ILLEGAL_TRAP_EN
    assign ill_act = 1'b0;
`endif

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] actual();
        e_t a;
        a = '{RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, ResultSrcE,
              ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
              Rs1E, Rs2E, RdE, ill_act};
        return a;
    endfunction

    function automatic e_t mk(input logic rw, input logic mw, input logic j, input logic b,
                              input logic as, input logic asa, input logic [1:0] rsrc,
                              input logic [3:0] ctl, input logic [2:0] f3,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic ill);
        e_t e;
        e = '{rw, mw, j, b, as, asa, rsrc, ctl, f3, rd1, rd2, imm, 32'd0, 32'd0,
              rs1, rs2, rd, ill};
`ifndef DECODE_ILLEGAL_TRAP_EN
        e.illegal = 1'b0;
`endif
        return e;
    endfunction

    // Driver: apply one cycle of inputs, queue the ID/EX expectation for the
    // following edge, and check the combinational source indices.
    task automatic step(input string name, input logic rst_v, input logic [31:0] instr,
                        input logic [31:0] pc, input logic wen, input logic [4:0] wrd,
                        input logic [31:0] wdata, input logic stall, input logic flush,
                        input logic [4:0] e_rs1d, input logic [4:0] e_rs2d, input e_t e_in);
        e_t e;
        @(negedge clk);
        rst       = rst_v;
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        RegWriteW = wen;
        RdW       = wrd;
        ResultW   = wdata;
        StallE    = stall;
        FlushE    = flush;
        e         = e_in;
        e.pc      = pc;
        e.pcp4    = pc + 32'd4;
        if (!rst_v || flush) e = '0;
        else if (stall)      e = last_e;
        last_e = e;
        exp_q.push_back(e);
        name_q.push_back(name);
        #1;
        checks++;
        if (Rs1D !== e_rs1d || Rs2D !== e_rs2d) begin
            failures++;
            $display("FAIL %s_srcD got rs1=%0d rs2=%0d exp rs1=%0d rs2=%0d",
                     name, Rs1D, Rs2D, e_rs1d, e_rs2d);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        RegWriteW = 1'b0;
        StallE    = 1'b1;
        FlushE    = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor: compare one queued entry after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [W-1:0] ex;
                string        nm;
                ex = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (actual() !== ex) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", nm, actual(), ex);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        e_t sltu_e;
        checks = 0; failures = 0; last_e = '0;
        rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; StallE = 1'b0; FlushE = 1'b0;
        sltu_e = mk(1,0,0,0,0,0,2'b00,4'h9,3'd3,32'h10,32'hDEADBEEF,32'h0,5'd2,5'd3,5'd12,0);

        step("reset",   0, 32'h00500093, 32'h100, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0, '0);
        step("addi",    1, 32'h00500093, 32'h104, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(1,0,0,0,1,0,2'b00,4'h0,3'd0,32'h0,32'h0,32'd5,5'd0,5'd0,5'd1,0));
        step("bypass",  1, 32'h003100B3, 32'h108, 1, 5'd3, 32'hDEADBEEF, 0, 0, 5'd2, 5'd3,
             mk(1,0,0,0,0,0,2'b00,4'h0,3'd0,32'h0,32'hDEADBEEF,32'h0,5'd2,5'd3,5'd1,0));
        step("sub",     1, 32'h40218233, 32'h10C, 1, 5'd2, 32'h10, 0, 0, 5'd3, 5'd2,
             mk(1,0,0,0,0,0,2'b00,4'h1,3'd0,32'hDEADBEEF,32'h10,32'h0,5'd3,5'd2,5'd4,0));
        step("x0_wr",   1, 32'h003002B3, 32'h110, 1, 5'd0, 32'h1234, 0, 0, 5'd0, 5'd3,
             mk(1,0,0,0,0,0,2'b00,4'h0,3'd0,32'h0,32'hDEADBEEF,32'h0,5'd0,5'd3,5'd5,0));
        step("x0_rd",   1, 32'h003043B3, 32'h114, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd3,
             mk(1,0,0,0,0,0,2'b00,4'h4,3'd4,32'h0,32'hDEADBEEF,32'h0,5'd0,5'd3,5'd7,0));
        step("beq",     1, 32'hFE000EE3, 32'h118, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(0,0,0,1,0,0,2'b00,4'h1,3'd0,32'h0,32'h0,32'hFFFFFFFC,5'd0,5'd0,5'd0,0));
        step("lw",      1, 32'hFF81A403, 32'h11C, 0, 5'd0, 32'h0, 0, 0, 5'd3, 5'd0,
             mk(1,0,0,0,1,0,2'b01,4'h0,3'd2,32'hDEADBEEF,32'h0,32'hFFFFFFF8,5'd3,5'd0,5'd8,0));
        step("sw",      1, 32'h00312623, 32'h120, 0, 5'd0, 32'h0, 0, 0, 5'd2, 5'd3,
             mk(0,1,0,0,1,0,2'b00,4'h0,3'd2,32'h10,32'hDEADBEEF,32'hC,5'd2,5'd3,5'd0,0));
        step("lui",     1, 32'h123454B7, 32'h124, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(1,0,0,0,1,0,2'b00,4'h0,3'd0,32'h0,32'h0,32'h12345000,5'd0,5'd0,5'd9,0));
        step("auipc",   1, 32'hFFFFF517, 32'h128, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(1,0,0,0,1,1,2'b00,4'h0,3'd0,32'h0,32'h0,32'hFFFFF000,5'd0,5'd0,5'd10,0));
        step("jal",     1, 32'h008000EF, 32'h12C, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(1,0,1,0,0,0,2'b10,4'h0,3'd0,32'h0,32'h0,32'h8,5'd0,5'd0,5'd1,0));
        step("jalr",    1, 32'h00008067, 32'h130, 0, 5'd0, 32'h0, 0, 0, 5'd1, 5'd0,
             mk(1,0,1,0,1,0,2'b10,4'h0,3'd0,32'h0,32'h0,32'h0,5'd1,5'd0,5'd0,0));
        step("srai",    1, 32'h4041D593, 32'h134, 0, 5'd0, 32'h0, 0, 0, 5'd3, 5'd0,
             mk(1,0,0,0,1,0,2'b00,4'h7,3'd5,32'hDEADBEEF,32'h0,32'h404,5'd3,5'd0,5'd11,0));
        step("sltu",    1, 32'h00313633, 32'h138, 0, 5'd0, 32'h0, 0, 0, 5'd2, 5'd3, sltu_e);
        step("flush_stall", 1, 32'h00313633, 32'h13C, 0, 5'd0, 32'h0, 1, 1, 5'd2, 5'd3, sltu_e);
        step("stall_bubble", 1, 32'h003043B3, 32'h140, 0, 5'd0, 32'h0, 1, 0, 5'd0, 5'd3, sltu_e);
        step("reload",  1, 32'h00313633, 32'h144, 0, 5'd0, 32'h0, 0, 0, 5'd2, 5'd3, sltu_e);
        step("stall_hold", 1, 32'h003043B3, 32'h148, 0, 5'd0, 32'h0, 1, 0, 5'd0, 5'd3, sltu_e);
        step("ill_op",  1, 32'hFFFFFFFF, 32'h14C, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(0,0,0,0,0,0,2'b00,4'h0,3'd0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1));
        step("ill_f7",  1, 32'h02310133, 32'h150, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(0,0,0,0,0,0,2'b00,4'h0,3'd0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1));
        step("ill_slli", 1, 32'h40311193, 32'h154, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0,
             mk(0,0,0,0,0,0,2'b00,4'h0,3'd0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1));
        step("post_ill", 1, 32'h00313633, 32'h158, 0, 5'd0, 32'h0, 0, 0, 5'd2, 5'd3, sltu_e);
        idle();

        // Asynchronous reset mid-cycle must clear outputs without an edge.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (actual() !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", actual());
        end
        // Register file must have been cleared as well.
        step("rf_cleared", 1, 32'h00313633, 32'h15C, 0, 5'd0, 32'h0, 0, 0, 5'd2, 5'd3,
             mk(1,0,0,0,0,0,2'b00,4'h9,3'd3,32'h0,32'h0,32'h0,5'd2,5'd3,5'd12,0));
        idle();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
